shift_reg_univ: RTL and testbench

Parametrised universal shift register, the successor to the fixed 4-bit parallel-in/parallel-out register. It supports hold, right shift, left shift and parallel load modes. A frame tracker reports when WIDTH shifts have completed since the last load. It serves as the common register stage for SIPO/PISO/SISO/PIPO datapaths in the serial-link and test-pattern blocks.

---
 rtl/shift_reg_pkg.sv | 37 +++
 rtl/shift_reg_frame_cnt.sv | 102 ++++++++++
 rtl/shift_reg_univ.sv | 111 +++++++++++
 tb/tb_shift_reg_univ.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
//
// Shared types for the universal shift register:
//   mode_e  - operating mode as presented on the mode port
//   state_e - frame tracker state
// Also holds small helpers that classify a mode value.
//
// Optional feature macro used by the block: SHIFT_REG_ROTATE_EN (see top).
// -----------------------------------------------------------------------------
package shift_reg_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SHIFTING = 2'b01,
    ST_DONE     = 2'b10
  } state_e;

  // True for either shift direction (rotations are shifts with another fill).
  function automatic logic is_shift(input mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

  function automatic logic is_load(input mode_e m);
    return (m == MODE_LOAD);
  endfunction

endpackage

// File: rtl/shift_reg_frame_cnt.sv
// -----------------------------------------------------------------------------
// shift_reg_frame_cnt
//
// Frame tracker for the universal shift register. Counts shifts after a
// parallel load and reports when WIDTH of them have completed.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   mode_i       in   current mode (hold / shr / shl / load)
//   busy_o       out  registered, high while a frame is in progress
//   frame_done_o out  registered one-cycle pulse after the WIDTH-th shift
//
// The counter is CNT_W = $clog2(WIDTH+1) bits wide so it can hold WIDTH
// itself; it stops at WIDTH and never wraps.
// -----------------------------------------------------------------------------
module shift_reg_frame_cnt
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MODE_W-1:0]    mode_i,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  mode_e            mode;
  logic             shift_req;
  logic             load_req;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             frame_done_q;

  assign mode      = mode_e'(mode_i);
  assign shift_req = is_shift(mode);
  assign load_req  = is_load(mode);

  // Single-process FSM; busy and frame_done are registered alongside the
  // state so they change on the same edge as the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Shifts move data in the datapath but are not counted here.
          if (load_req) begin
            state_q <= ST_SHIFTING;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_SHIFTING: begin
          if (load_req) begin
            // Reload restarts the frame without leaving SHIFTING.
            cnt_q <= '0;
          end else if (shift_req) begin
            if (cnt_q >= CNT_LAST) begin
              state_q      <= ST_DONE;
              cnt_q        <= CNT_FULL;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (load_req) begin
            state_q <= ST_SHIFTING;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
//
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load, plus a frame tracker that flags when WIDTH shifts have
// completed since the last load. Usable as SIPO / PISO / SISO / PIPO stage.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   mode        in   2  00 hold, 01 shift right, 10 shift left, 11 load
//   d           in   WIDTH  parallel load data
//   sin         in   serial input
//   rot         in   rotate select (only with SHIFT_REG_ROTATE_EN)
//   q           out  WIDTH  register contents
//   so_r        out  right-shift serial output (q[0], combinational)
//   so_l        out  left-shift serial output (q[WIDTH-1], combinational)
//   busy        out  high while a frame is in progress
//   frame_done  out  one-cycle pulse after the WIDTH-th shift of a frame
//
// Build option: define SHIFT_REG_ROTATE_EN to add the rot port; with rot=1
// the bit shifted out re-enters at the other end and sin is ignored.
// -----------------------------------------------------------------------------
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MODE_W-1:0]  mode,
  input  logic [WIDTH-1:0]   d,
  input  logic               sin,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic               rot,
`endif
  output logic [WIDTH-1:0]   q,
  output logic               so_r,
  output logic               so_l,
  output logic               busy,
  output logic               frame_done
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;
  logic             fill_r;
  logic             fill_l;

  // Bit entering at the MSB on a right shift / at the LSB on a left shift.
`ifdef SHIFT_REG_ROTATE_EN
  assign fill_r = rot ? q_q[0]       : sin;
  assign fill_l = rot ? q_q[WIDTH-1] : sin;
`else
  assign fill_r = sin;
  assign fill_l = sin;
`endif

  // Per-bit neighbour selection for both shift directions.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH - 1) begin : g_msb
        assign shr_val[gi] = fill_r;
      end else begin : g_nmsb
        assign shr_val[gi] = q_q[gi+1];
      end

      if (gi == 0) begin : g_lsb
        assign shl_val[gi] = fill_l;
      end else begin : g_nlsb
        assign shl_val[gi] = q_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    case (mode_e'(mode))
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = shr_val;
      MODE_SHL:  q_d = shl_val;
      MODE_LOAD: q_d = d;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  shift_reg_frame_cnt #(
    .WIDTH (WIDTH)
  ) u_frame_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_i       (mode),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  assign q    = q_q;
  assign so_r = q_q[0];
  assign so_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_univ
//
// Directed bench for shift_reg_univ (WIDTH=4). A behavioural model tracks the
// register value arithmetically and the frame as "shifts since last load";
// a compare process checks every output against it on each falling edge.
// Directed sequences additionally check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_shift_reg_univ;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic         sin;
`ifdef SHIFT_REG_ROTATE_EN
  logic         rot;
`endif
  logic [W-1:0] q;
  logic         so_r;
  logic         so_l;
  logic         busy;
  logic         frame_done;

  int total = 0;
  int bad   = 0;

  shift_reg_univ #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .d          (d),
    .sin        (sin),
`ifdef SHIFT_REG_ROTATE_EN
    .rot        (rot),
`endif
    .q          (q),
    .so_r       (so_r),
    .so_l       (so_l),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int unsigned m_q;
  int          m_shifts;   // shifts counted since the last load
  bit          m_loaded;   // a load has happened since reset
  bit          m_fd;

  always @(posedge clk or negedge rst_n) begin : model
    int unsigned fill;
    bit          shifted;
    if (!rst_n) begin
      m_q      = 0;
      m_shifts = 0;
      m_loaded = 0;
      m_fd     = 0;
    end else begin
      m_fd    = 0;
      shifted = 0;
      fill    = 32'(sin);
`ifdef SHIFT_REG_ROTATE_EN
      if (rot) fill = (mode == 2'b01) ? (m_q & 1) : ((m_q >> (W - 1)) & 1);
`endif
      case (mode)
        2'b01: begin m_q = (m_q >> 1) | (fill << (W - 1)); shifted = 1; end
        2'b10: begin m_q = ((m_q << 1) | fill) & MASK;     shifted = 1; end
        2'b11: begin m_q = 32'(d); m_loaded = 1; m_shifts = 0; end
        default: ;
      endcase
      if (shifted && m_loaded && m_shifts < W) begin
        m_shifts = m_shifts + 1;
        if (m_shifts == W) m_fd = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      total = total + 1;
      if ({28'd0, q} !== m_q || so_r !== m_q[0] || so_l !== m_q[W-1] ||
          busy !== (m_loaded && m_shifts < W) || frame_done !== m_fd) begin
        bad = bad + 1;
        $display("FAIL model_cmp t=%0t q=%b so_r=%b so_l=%b busy=%b fd=%b required q=%b busy=%b fd=%b",
                 $time, q, so_r, so_l, busy, frame_done, m_q[W-1:0],
                 (m_loaded && m_shifts < W), m_fd);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step(input logic [1:0] m, input logic [W-1:0] dv, input logic s);
    mode = m;
    d    = dv;
    sin  = s;
    @(posedge clk);
    #1;
  endtask

  // Bound the whole run.
  initial begin
    #50000;
    $display("FAIL watchdog run did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  logic [W-1:0] piso_q[4]   = '{4'b0110, 4'b0011, 4'b0001, 4'b0000};
  logic         piso_sor[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] sipo_q[4]   = '{4'b1011, 4'b0111, 4'b1111, 4'b1111};
  logic [W-1:0] rot_q[4]    = '{4'b1110, 4'b0111, 4'b1011, 4'b1101};

  initial begin
    rst_n = 1'b0;
    mode  = 2'b00;
    d     = '0;
    sin   = 1'b0;
`ifdef SHIFT_REG_ROTATE_EN
    rot   = 1'b0;
`endif
    #12;
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_fd", 32'(frame_done), 32'h0);
    #11 rst_n = 1'b1;   // release away from a clock edge

    // Asynchronous reset mid-cycle with live data
    step(2'b11, 4'b1010, 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", 32'(q), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_fd", 32'(frame_done), 32'h0);
    #1 rst_n = 1'b1;

    // PISO: load 1100, four right shifts with sin=0
    step(2'b11, 4'b1100, 1'b0);
    chk("piso_load_q", 32'(q), 32'hC);
    chk("piso_load_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("piso_sor_before_%0d", i), 32'(so_r), 32'(piso_sor[i]));
      step(2'b01, 4'b0000, 1'b0);
      chk($sformatf("piso_q_%0d", i), 32'(q), 32'(piso_q[i]));
      chk($sformatf("piso_fd_%0d", i), 32'(frame_done), (i == 3) ? 32'h1 : 32'h0);
      chk($sformatf("piso_busy_%0d", i), 32'(busy), (i == 3) ? 32'h0 : 32'h1);
    end
    step(2'b00, 4'b0000, 1'b0);
    chk("piso_fd_after", 32'(frame_done), 32'h0);
    step(2'b01, 4'b0000, 1'b1);
    chk("done_shift_q", 32'(q), 32'h8);
    chk("done_shift_fd", 32'(frame_done), 32'h0);

    // SIPO: load 1101, four left shifts with sin=1
    step(2'b11, 4'b1101, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 4'b0000, 1'b1);
      chk($sformatf("sipo_q_%0d", i), 32'(q), 32'(sipo_q[i]));
      chk($sformatf("sipo_sol_%0d", i), 32'(so_l), 32'(sipo_q[i][W-1]));
      chk($sformatf("sipo_fd_%0d", i), 32'(frame_done), (i == 3) ? 32'h1 : 32'h0);
    end

    // Reload mid-frame with holds and mixed directions
    step(2'b11, 4'b1111, 1'b0);
    step(2'b01, 4'b0000, 1'b0);
    step(2'b10, 4'b0000, 1'b0);
    step(2'b11, 4'b0110, 1'b0);
    chk("reload_q", 32'(q), 32'h6);
    step(2'b00, 4'b0000, 1'b1);
    step(2'b00, 4'b0000, 1'b1);
    chk("reload_hold_q", 32'(q), 32'h6);
    for (int i = 0; i < 4; i++) begin
      step(2'b01, 4'b0000, 1'b0);
      chk($sformatf("reload_fd_%0d", i), 32'(frame_done), (i == 3) ? 32'h1 : 32'h0);
      if (i == 1) begin
        step(2'b00, 4'b0000, 1'b0);
        chk("reload_mid_hold_fd", 32'(frame_done), 32'h0);
        chk("reload_mid_hold_busy", 32'(busy), 32'h1);
      end
    end
    chk("reload_end_q", 32'(q), 32'h0);

    // Reset mid-frame, then shifting must not start a frame
    step(2'b11, 4'b1101, 1'b0);
    step(2'b01, 4'b0000, 1'b0);
    chk("midrst_pre_q", 32'(q), 32'h6);
    rst_n = 1'b0;
    #1;
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 4'b0000, 1'b1);
      chk($sformatf("idle_busy_%0d", i), 32'(busy), 32'h0);
      chk($sformatf("idle_fd_%0d", i), 32'(frame_done), 32'h0);
    end
    chk("idle_shift_q", 32'(q), 32'hF);

`ifdef SHIFT_REG_ROTATE_EN
    // Right rotate: load 1101, four rotations, sin ignored
    step(2'b11, 4'b1101, 1'b0);
    rot = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(2'b01, 4'b0000, 1'b0);
      chk($sformatf("rot_q_%0d", i), 32'(q), 32'(rot_q[i]));
      chk($sformatf("rot_fd_%0d", i), 32'(frame_done), (i == 3) ? 32'h1 : 32'h0);
    end
    // Left rotate, sin=0 ignored: 1101 -> 1011
    step(2'b10, 4'b0000, 1'b0);
    chk("rotl_q", 32'(q), 32'hB);
    rot = 1'b0;
`endif

    step(2'b00, 4'b0000, 1'b0);
    step(2'b00, 4'b0000, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
